// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and constants for the instruction-memory loader.
// Optional checksum support is selected with the IMEM_LOADER_CHECKSUM_EN macro
// in imem_loader.sv; the state enum always carries the CSUM encoding.
package imem_loader_pkg;

    // Frame layout constants
    localparam int HDR_BYTES       = 2;
    localparam int BYTES_PER_WORD  = 4;
    localparam int WORD_W          = 32;
    localparam int BYTE_IDX_W      = $clog2(BYTES_PER_WORD);

    // Default instruction-memory word-address width (1024-word CPU memory)
    localparam int IMEM_ADDR_WIDTH = 10;

    // Loader FSM states
    typedef enum logic [2:0] {
        ST_HDR_HI = 3'd0,
        ST_HDR_LO = 3'd1,
        ST_DATA   = 3'd2,
        ST_WRITE  = 3'd3,
        ST_CSUM   = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } loader_state_e;

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream input and instruction-memory write port of the loader.
//
// Handshake: a byte transfers on a rising clk edge where in_valid && in_ready.
// The host holds in_data stable while in_valid is high and not yet accepted;
// in_ready depends only on loader state, never on in_valid. mem_we is a
// one-cycle strobe per assembled word with mem_addr/mem_wdata valid alongside.
interface imem_loader_if #(
    parameter int ADDR_WIDTH = 10
);
    logic [7:0]            in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;

    // Host link / memory observer side
    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

    // Loader side
    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );
endinterface

// File: rtl/imem_word_assembler.sv
// imem_word_assembler: 8->32 bit big-endian shift register with byte counter.
// word_valid_o pulses combinationally alongside the 4th accepted byte, so the
// completed word appears on word_o from the following cycle.
module imem_word_assembler
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_i,
    output logic [WORD_W-1:0] word_o,
    output logic              word_valid_o
);
    localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(BYTES_PER_WORD - 1);

    logic [WORD_W-1:0]     word_q, word_d;
    logic [BYTE_IDX_W-1:0] idx_q, idx_d;

    // Shift each byte in from the LSB side so the first byte ends up as the MSB
    always_comb begin
        word_d = word_q;
        idx_d  = idx_q;
        if (clear_i) begin
            word_d = '0;
            idx_d  = '0;
        end else if (byte_valid_i) begin
            word_d = {word_q[WORD_W-9:0], byte_i};
            idx_d  = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end
    end

    // Shift register and byte index state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_q <= '0;
            idx_q  <= '0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
        end
    end

    assign word_o       = word_q;
    assign word_valid_o = byte_valid_i && !clear_i && (idx_q == LAST_IDX);

endmodule

// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream loader that fills instruction memory from
// word 0 and holds the CPU in reset until a whole frame has been written.
// Frame: N[15:8], N[7:0], N x 4 data bytes (MSB first), optional checksum.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = IMEM_ADDR_WIDTH,
    parameter int DATA_WIDTH = WORD_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    imem_loader_if.slave        bus,
    output logic                cpu_reset,
    output logic                done,
    output logic                error,
    output logic [ADDR_WIDTH:0] words_loaded,
    output loader_state_e       dbg_state_o
);
    // 17 bits holds both the 16-bit header count and 2**ADDR_WIDTH
    localparam int               CNT_W     = 17;
    localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(1) << ADDR_WIDTH;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam loader_state_e FRAME_END_ST = ST_CSUM;
`else
    localparam loader_state_e FRAME_END_ST = ST_DONE;
`endif

    if (DATA_WIDTH != WORD_W) begin : g_bad_data_width
        $error("imem_loader: DATA_WIDTH must be 32");
    end
    if (ADDR_WIDTH < 1 || ADDR_WIDTH > 16) begin : g_bad_addr_width
        $error("imem_loader: ADDR_WIDTH must be in 1..16");
    end

    loader_state_e         state_q, state_d;
    logic [15:0]           n_q, n_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   words_q, words_d;

    logic              ready;
    logic              accept;
    logic              restart;
    logic [15:0]       hdr_n;
    logic              asm_byte_valid;
    logic              word_valid;
    logic [WORD_W-1:0] word;
    logic              last_word;

    assign ready = (state_q == ST_HDR_HI) || (state_q == ST_HDR_LO) ||
                   (state_q == ST_DATA)   || (state_q == ST_CSUM);
    assign accept         = bus.in_valid && ready;
    // start only acts from a terminal state; in_ready is low there, so a byte
    // presented in the same cycle is never consumed
    assign restart        = start && ((state_q == ST_DONE) || (state_q == ST_ERR));
    assign hdr_n          = {n_q[15:8], bus.in_data};
    assign asm_byte_valid = accept && (state_q == ST_DATA);
    assign last_word      = (CNT_W'(words_q) + CNT_W'(1)) == {1'b0, n_q};

    imem_word_assembler u_asm (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (restart),
        .byte_valid_i (asm_byte_valid),
        .byte_i       (bus.in_data),
        .word_o       (word),
        .word_valid_o (word_valid)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;

    // Running XOR over header and data bytes; the checksum byte itself is excluded
    always_comb begin
        csum_d = csum_q;
        if (restart) begin
            csum_d = '0;
        end else if (accept && (state_q != ST_CSUM)) begin
            csum_d = csum_q ^ bus.in_data;
        end
    end

    // Checksum accumulator register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif

    // Next-state logic for frame parsing, address and word counters
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        addr_d  = addr_q;
        words_d = words_q;
        case (state_q)
            ST_HDR_HI: begin
                if (accept) begin
                    n_d[15:8] = bus.in_data;
                    state_d   = ST_HDR_LO;
                end
            end
            ST_HDR_LO: begin
                if (accept) begin
                    n_d[7:0] = bus.in_data;
                    if ({1'b0, hdr_n} > MAX_WORDS) begin
                        state_d = ST_ERR;
                    end else if (hdr_n == 16'd0) begin
                        state_d = FRAME_END_ST;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (word_valid) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                addr_d  = addr_q + 1'b1;
                words_d = words_q + 1'b1;
                state_d = last_word ? FRAME_END_ST : ST_DATA;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (accept) begin
                    state_d = (bus.in_data == csum_q) ? ST_DONE : ST_ERR;
                end
            end
`endif
            ST_DONE, ST_ERR: begin
                if (restart) begin
                    state_d = ST_HDR_HI;
                    addr_d  = '0;
                    words_d = '0;
                end
            end
            default: begin
                state_d = ST_HDR_HI;
            end
        endcase
    end

    // FSM state, header count and address/word counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_HDR_HI;
            n_q     <= '0;
            addr_q  <= '0;
            words_q <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            addr_q  <= addr_d;
            words_q <= words_d;
        end
    end

    assign bus.in_ready  = ready;
    assign bus.mem_we    = (state_q == ST_WRITE);
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = word;
    assign cpu_reset     = (state_q != ST_DONE);
    assign done          = (state_q == ST_DONE);
    assign error         = (state_q == ST_ERR);
    assign words_loaded  = words_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed and randomized frames for imem_loader (ADDR_WIDTH=4),
// scored against a frame-level model of expected memory writes.
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int AW = 4;
    localparam int W  = AW + 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          cpu_reset;
    logic          done;
    logic          error;
    logic [AW:0]   words_loaded;
    loader_state_e dbg_state;

    int n_cmp = 0;
    int n_mis = 0;

    logic [W-1:0]  exp_q[$];
    logic [W-1:0]  got_q[$];
    logic [31:0]   wq[$];

    imem_loader_if #(.ADDR_WIDTH(AW)) bus ();

    imem_loader #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (32)
    ) dut (
        .clk          (clk),
        .reset        (rst_n),
        .start        (start),
        .bus          (bus),
        .cpu_reset    (cpu_reset),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded),
        .dbg_state_o  (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Capture every memory write; input must be stalled during a write cycle
    always @(negedge clk) begin
        if (rst_n && bus.mem_we === 1'b1) begin
            got_q.push_back({bus.mem_addr, bus.mem_wdata});
            check("ready_low_in_write", 64'(bus.in_ready), 64'd0);
        end
    end

    // Present one byte after a random idle gap, wait (bounded) for its handshake.
    // Called and returns at #1 after a rising edge.
    task automatic send_byte(input logic [7:0] b, input int max_gap, output bit ok);
        int   gap;
        logic rdy;
        gap = $urandom_range(0, max_gap);
        repeat (gap) begin
            bus.in_valid = 1'b0;
            bus.in_data  = 8'($urandom);
            @(posedge clk); #1;
        end
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 50; t++) begin
            rdy = bus.in_ready;
            @(posedge clk); #1;
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Send a frame of header n with words from wq, then score the outcome.
    // csum_flip != 0 corrupts the checksum byte when checksums are enabled.
    task automatic run_frame(input logic [15:0] n, input int max_gap,
                             input logic [7:0] csum_flip, input string tag);
        logic [7:0] fb[$];
        bit         ok;
        bit         exp_err;
        int         nw;
        int         exp_words;
        exp_err = (int'(n) > (1 << AW));
        nw      = exp_err ? 0 : int'(n);
        fb.delete();
        fb.push_back(n[15:8]);
        fb.push_back(n[7:0]);
        for (int i = 0; i < nw; i++) begin
            for (int b = 3; b >= 0; b--) fb.push_back(wq[i][8*b +: 8]);
        end
        exp_q.delete();
        got_q.delete();
        for (int i = 0; i < nw; i++) exp_q.push_back({AW'(i), wq[i]});
        exp_words = nw;
`ifdef IMEM_LOADER_CHECKSUM_EN
        begin
            logic [7:0] cs;
            cs = 8'h00;
            foreach (fb[i]) cs = cs ^ fb[i];
            if (!exp_err) begin
                if (csum_flip != 8'h00) exp_err = 1'b1;
                fb.push_back(cs ^ csum_flip);
            end
        end
`endif
        for (int i = 0; i < fb.size(); i++) begin
            send_byte(fb[i], max_gap, ok);
            check({tag, "_byte_accepted"}, 64'(ok), 64'd1);
            if (!ok) break;
            if (i >= 2 && i < 2 + 4 * nw && ((i - 2) % 4) == 3) begin
                check({tag, "_we_after_4th"}, 64'(bus.mem_we), 64'd1);
            end
        end
        for (int t = 0; t < 40; t++) begin
            if (done === 1'b1 || error === 1'b1) break;
            @(posedge clk); #1;
        end
        check({tag, "_done"},         64'(done),         64'(!exp_err));
        check({tag, "_error"},        64'(error),        64'(exp_err));
        check({tag, "_cpu_reset"},    64'(cpu_reset),    64'(exp_err));
        check({tag, "_in_ready"},     64'(bus.in_ready), 64'd0);
        check({tag, "_words_loaded"}, 64'(words_loaded), 64'(exp_words));
        check({tag, "_mem_addr"},     64'(bus.mem_addr), 64'(exp_words % (1 << AW)));
        check({tag, "_write_count"},  64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check({tag, "_write"}, 64'(got_q[i]), 64'(exp_q[i]));
        end
    endtask

    initial begin
        bit ok;
        int n;
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready",     64'(bus.in_ready),  64'd1);
        check("reset_mem_we",       64'(bus.mem_we),    64'd0);
        check("reset_mem_addr",     64'(bus.mem_addr),  64'd0);
        check("reset_mem_wdata",    64'(bus.mem_wdata), 64'd0);
        check("reset_cpu_reset",    64'(cpu_reset),     64'd1);
        check("reset_done",         64'(done),          64'd0);
        check("reset_error",        64'(error),         64'd0);
        check("reset_words_loaded", 64'(words_loaded),  64'd0);
        check("reset_state",        64'(dbg_state),     64'(ST_HDR_HI));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Nominal two-word frame, no gaps
        wq.delete();
        wq.push_back(32'h20080001);
        wq.push_back(32'h20090007);
        run_frame(16'd2, 0, 8'h00, "nominal");

        // Bytes offered in DONE are back-pressured; start wins over a byte
        bus.in_data  = 8'hAA;
        bus.in_valid = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("done_backpressure", 64'(bus.in_ready), 64'd0);
        end
        check("done_no_extra_write", 64'(got_q.size()), 64'd2);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        bus.in_valid = 1'b0;
        check("start_done_clear",   64'(done),         64'd0);
        check("start_cpu_reset",    64'(cpu_reset),    64'd1);
        check("start_words_loaded", 64'(words_loaded), 64'd0);
        check("start_mem_addr",     64'(bus.mem_addr), 64'd0);
        check("start_in_ready",     64'(bus.in_ready), 64'd1);

        // Same frame with random in_valid gaps
        run_frame(16'd2, 3, 8'h00, "gapped");
        pulse_start();

        // Random frames, including a full-capacity frame that wraps mem_addr
        for (int k = 0; k < 5; k++) begin
            n = (k == 0) ? (1 << AW) : $urandom_range(1, 1 << AW);
            wq.delete();
            for (int i = 0; i < n; i++) wq.push_back($urandom);
            run_frame(16'(n), 2, 8'h00, "random");
            pulse_start();
        end

        // Zero-length frame
        wq.delete();
        run_frame(16'd0, 1, 8'h00, "zero");
        pulse_start();

        // Oversize header (2**AW + 1 words)
        run_frame(16'h0011, 0, 8'h00, "oversize");
        pulse_start();

        // Reset in the middle of a word discards the partial load
        got_q.delete();
        send_byte(8'h00, 0, ok);
        send_byte(8'h01, 0, ok);
        send_byte(8'h20, 0, ok);
        send_byte(8'h08, 0, ok);
        check("midword_bytes_accepted", 64'(ok), 64'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midword_no_write",  64'(got_q.size()),  64'd0);
        check("midword_cpu_reset", 64'(cpu_reset),     64'd1);
        check("midword_in_ready",  64'(bus.in_ready),  64'd1);
        check("midword_wdata",     64'(bus.mem_wdata), 64'd0);
        wq.delete();
        wq.push_back(32'hDEADBEEF);
        run_frame(16'd1, 0, 8'h00, "after_reset");

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Bad then good checksum, reloading from address 0 after start
        pulse_start();
        wq.delete();
        wq.push_back(32'h11223344);
        run_frame(16'd1, 0, 8'h01, "csum_bad");
        pulse_start();
        run_frame(16'd1, 1, 8'h00, "csum_good");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
